// File: rtl/fwd_scoreboard.sv
// Forwarding and load-use hazard unit for the decode stage.
// Tracks in-flight writers in a private shift register and keeps a saturating stall-cycle counter.
module fwd_scoreboard #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NREAD    = 3,
  parameter int DEPTH    = 3,
  parameter int LOAD_LAT = 1,
  parameter int ZERO_REG = 0,
  parameter int CNT_W    = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    id_valid,
  input  logic [NREAD-1:0]        id_rd_used,
  input  logic [NREAD*ADDR_W-1:0] id_rd_addr,
  input  logic [NREAD*DATA_W-1:0] id_rd_data,
  input  logic                    id_wr_en,
  input  logic [ADDR_W-1:0]       id_wr_addr,
  input  logic                    id_is_load,
  input  logic                    flush,
  input  logic [DEPTH*DATA_W-1:0] stage_data,
  output logic [NREAD*DATA_W-1:0] fwd_data,
  output logic                    do_hazard,
  output logic [CNT_W-1:0]        stall_count
);

  typedef struct packed {
    logic              v;
    logic [ADDR_W-1:0] addr;
    logic              is_load;
  } entry_t;

  entry_t           ents [DEPTH];
  logic [NREAD-1:0] found;
  logic [NREAD-1:0] port_stall;

  // The youngest match decides: forward it if ready, otherwise stall rather than
  // falling through to an older (stale) producer of the same register.
  always_comb begin
    // NOTE: blocking assignments with every output defaulted first, so no latch is inferred.
    fwd_data   = id_rd_data;
    found      = '0;
    port_stall = '0;
    for (int i = 0; i < NREAD; i++) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (!found[i] && id_rd_used[i] && ents[k].v &&
            ents[k].addr == id_rd_addr[i*ADDR_W +: ADDR_W] &&
            (ZERO_REG == 0 || ents[k].addr != '0)) begin
          found[i] = 1'b1;
          if (!ents[k].is_load || k >= LOAD_LAT)
            fwd_data[i*DATA_W +: DATA_W] = stage_data[k*DATA_W +: DATA_W];
          else
            port_stall[i] = 1'b1;
        end
      end
    end
  end

  assign do_hazard = id_valid && !flush && (|port_stall);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      // NOTE: the entry array is a handful of flops, not a RAM, so it takes the async reset.
      for (int k = 0; k < DEPTH; k++) ents[k] <= '0;
      stall_count <= '0;
    end else begin
      if (flush) begin
        for (int k = 0; k < DEPTH; k++) ents[k] <= '0;
      end else begin
        for (int k = DEPTH-1; k > 0; k--) ents[k] <= ents[k-1];
        // A stalled decode pushes a bubble so the blocking load keeps advancing.
        ents[0].v       <= id_valid && id_wr_en && !do_hazard;
        ents[0].addr    <= id_wr_addr;
        ents[0].is_load <= id_is_load;
      end
      if (do_hazard && stall_count != {CNT_W{1'b1}})
        stall_count <= stall_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed bench: dut_a uses default parameters, dut_b uses LOAD_LAT=2, ZERO_REG=1, CNT_W=4.
`timescale 1ns/100ps
module tb_fwd_scoreboard;

  localparam int unsigned A0 = 'hA0;
  localparam int unsigned A1 = 'hA1;
  localparam int unsigned A2 = 'hA2;

  typedef struct {
    int unsigned valid, wr_en, wr_addr, is_load;
    int unsigned used, a0, a1, a2;
    int unsigned flush;
    int unsigned sd0, sd1, sd2;
    int unsigned haz_a, ck_fa, fa, cnt_a;
    int unsigned haz_b, ck_fb, fb, cnt_b;
    int unsigned ck_f1, f1;
  } vec_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        id_valid;
  logic [2:0]  id_rd_used;
  logic [14:0] id_rd_addr;
  logic [95:0] id_rd_data;
  logic        id_wr_en;
  logic [4:0]  id_wr_addr;
  logic        id_is_load;
  logic        flush;
  logic [95:0] stage_data;
  logic [95:0] fwd_a, fwd_b;
  logic        haz_a, haz_b;
  logic [15:0] cnt_a;
  logic [3:0]  cnt_b;

  int n_checks = 0;
  int n_err    = 0;

  fwd_scoreboard dut_a (
    .clock(clock), .reset(reset), .id_valid(id_valid), .id_rd_used(id_rd_used),
    .id_rd_addr(id_rd_addr), .id_rd_data(id_rd_data), .id_wr_en(id_wr_en),
    .id_wr_addr(id_wr_addr), .id_is_load(id_is_load), .flush(flush),
    .stage_data(stage_data), .fwd_data(fwd_a), .do_hazard(haz_a), .stall_count(cnt_a)
  );

  fwd_scoreboard #(.LOAD_LAT(2), .ZERO_REG(1), .CNT_W(4)) dut_b (
    .clock(clock), .reset(reset), .id_valid(id_valid), .id_rd_used(id_rd_used),
    .id_rd_addr(id_rd_addr), .id_rd_data(id_rd_data), .id_wr_en(id_wr_en),
    .id_wr_addr(id_wr_addr), .id_is_load(id_is_load), .flush(flush),
    .stage_data(stage_data), .fwd_data(fwd_b), .do_hazard(haz_b), .stall_count(cnt_b)
  );

  always #10 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    id_valid   = v.valid[0];
    id_wr_en   = v.wr_en[0];
    id_wr_addr = 5'(v.wr_addr);
    id_is_load = v.is_load[0];
    id_rd_used = 3'(v.used);
    id_rd_addr = {5'(v.a2), 5'(v.a1), 5'(v.a0)};
    flush      = v.flush[0];
    stage_data = {32'(v.sd2), 32'(v.sd1), 32'(v.sd0)};
  endtask

  function automatic vec_t mkin(input int unsigned valid, wr_en, wr_addr, is_load, used, a0);
    vec_t v;
    v = '{default: 0};
    v.valid = valid; v.wr_en = wr_en; v.wr_addr = wr_addr; v.is_load = is_load;
    v.used = used; v.a0 = a0;
    return v;
  endfunction

  vec_t vecs [17];

  initial begin
    // valid wr_en wr_addr is_load | used a0 a1 a2 | flush | sd0 sd1 sd2 |
    // haz_a ck_fa fa cnt_a | haz_b ck_fb fb cnt_b | ck_f1 f1
    vecs[0]  = '{1,1,3,0, 0,0,0,0, 0, 0,0,0,                0,1,A0,0,       0,1,A0,0,       1,A1};
    vecs[1]  = '{1,0,0,0, 1,3,9,0, 0, 'h1234,0,0,           0,1,'h1234,0,   0,1,'h1234,0,   1,A1};
    vecs[2]  = '{1,1,5,1, 3,3,3,0, 0, 0,'h5555,0,           0,1,'h5555,0,   0,1,'h5555,0,   1,'h5555};
    vecs[3]  = '{1,1,6,0, 1,5,0,0, 0, 'h0BAD,0,0,           1,0,0,0,        1,0,0,0,        0,0};
    vecs[4]  = '{1,1,6,0, 1,5,0,0, 0, 'h0BAD,'hCAFE,0,      0,1,'hCAFE,1,   1,0,0,1,        0,0};
    vecs[5]  = '{1,1,6,0, 1,5,0,0, 0, 'h0BAD,'h1111,'hCAFE, 0,1,'hCAFE,1,   0,1,'hCAFE,2,   0,0};
    vecs[6]  = '{1,1,7,0, 0,0,0,0, 0, 0,0,0,                0,1,A0,1,       0,1,A0,2,       0,0};
    vecs[7]  = '{1,0,0,0, 1,6,0,0, 0, 'h60,'h61,'h62,       0,1,'h61,1,     0,1,'h61,2,     0,0};
    vecs[8]  = '{1,1,7,0, 0,0,0,0, 0, 0,0,0,                0,1,A0,1,       0,1,A0,2,       0,0};
    vecs[9]  = '{1,1,7,1, 1,7,0,0, 0, 0,'h11,'h22,          0,1,0,1,        0,1,0,2,        0,0};
    vecs[10] = '{1,0,0,0, 1,7,0,0, 0, 'h33,'h11,0,          1,0,0,1,        1,0,0,2,        0,0};
    vecs[11] = '{1,1,7,0, 1,7,0,0, 1, 0,'h77,'h22,          0,1,'h77,2,     0,0,0,3,        0,0};
    vecs[12] = '{1,0,0,0, 7,7,3,6, 0, 'h99,'h99,'h99,       0,1,A0,2,       0,1,A0,3,       1,A1};
    vecs[13] = '{1,1,0,0, 0,0,0,0, 0, 0,0,0,                0,1,A0,2,       0,1,A0,3,       0,0};
    vecs[14] = '{1,1,0,1, 1,0,0,0, 0, 'h0F0F,0,0,           0,1,'h0F0F,2,   0,1,A0,3,       0,0};
    vecs[15] = '{1,0,0,0, 1,0,0,0, 0, 'h0F0F,'h0E0E,0,      1,0,0,2,        0,1,A0,3,       0,0};
    vecs[16] = '{0,0,0,0, 0,0,0,0, 0, 0,0,0,                0,1,A0,3,       0,1,A0,3,       0,0};

    id_rd_data = {32'(A2), 32'(A1), 32'(A0)};
    drive(mkin(1, 0, 0, 0, 7, 5));
    repeat (2) @(negedge clock);
    check("reset haz_a", 32'(haz_a), 0);
    check("reset haz_b", 32'(haz_b), 0);
    check("reset cnt_a", 32'(cnt_a), 0);
    check("reset cnt_b", 32'(cnt_b), 0);
    reset = 1'b0;

    for (int i = 0; i < 17; i++) begin
      @(negedge clock);
      drive(vecs[i]);
      #1;
      check($sformatf("row%0d haz_a", i), 32'(haz_a), vecs[i].haz_a);
      check($sformatf("row%0d haz_b", i), 32'(haz_b), vecs[i].haz_b);
      check($sformatf("row%0d cnt_a", i), 32'(cnt_a), vecs[i].cnt_a);
      check($sformatf("row%0d cnt_b", i), 32'(cnt_b), vecs[i].cnt_b);
      if (vecs[i].ck_fa != 0) check($sformatf("row%0d fwd0_a", i), fwd_a[31:0], vecs[i].fa);
      if (vecs[i].ck_fb != 0) check($sformatf("row%0d fwd0_b", i), fwd_b[31:0], vecs[i].fb);
      if (vecs[i].ck_f1 != 0) begin
        check($sformatf("row%0d fwd1_a", i), fwd_a[63:32], vecs[i].f1);
        check($sformatf("row%0d fwd1_b", i), fwd_b[63:32], vecs[i].f1);
      end
    end

    // Clear counters, then repeat load-use pairs until dut_b's 4-bit counter saturates.
    @(negedge clock);
    drive(mkin(0, 0, 0, 0, 0, 0));
    reset = 1'b1;
    #1;
    check("clr cnt_a", 32'(cnt_a), 0);
    check("clr cnt_b", 32'(cnt_b), 0);
    reset = 1'b0;
    for (int r = 0; r < 10; r++) begin
      @(negedge clock);
      drive(mkin(1, 1, 5, 1, 0, 0));
      for (int c = 0; c < 3; c++) begin
        @(negedge clock);
        drive(mkin(1, 0, 0, 0, 1, 5));
        #1;
        if (c == 0) begin
          check($sformatf("sat%0d haz_a", r), 32'(haz_a), 1);
          check($sformatf("sat%0d haz_b", r), 32'(haz_b), 1);
        end
        if (c == 2) begin
          check($sformatf("sat%0d haz_b_end", r), 32'(haz_b), 0);
          check($sformatf("sat%0d cnt_a", r), 32'(cnt_a), 32'(r + 1));
          check($sformatf("sat%0d cnt_b", r), 32'(cnt_b), (2 * (r + 1) > 15) ? 15 : 32'(2 * (r + 1)));
        end
      end
    end

    // Reset asserted in the middle of a stalled cycle takes effect before the next edge.
    @(negedge clock);
    drive(mkin(1, 1, 5, 1, 0, 0));
    @(negedge clock);
    drive(mkin(1, 0, 0, 0, 1, 5));
    #1;
    check("mid haz_a before", 32'(haz_a), 1);
    check("mid haz_b before", 32'(haz_b), 1);
    #1 reset = 1'b1;
    #1;
    check("mid haz_a in reset", 32'(haz_a), 0);
    check("mid haz_b in reset", 32'(haz_b), 0);
    check("mid cnt_a in reset", 32'(cnt_a), 0);
    check("mid cnt_b in reset", 32'(cnt_b), 0);
    #1 reset = 1'b0;
    #1;
    check("mid haz_a after", 32'(haz_a), 0);
    check("mid fwd0_a after", fwd_a[31:0], A0);
    @(negedge clock);
    #1;
    check("post cnt_a", 32'(cnt_a), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
